// File: rtl/byte_word_packer.sv
// Multi-lane sample-to-word packer with a shared frame phase counter.
// Emits one word per lane per frame, or flags the lane when the frame is partial.
module byte_word_packer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int LANES     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                          clk_4f_c,
  input  logic                          reset,
  input  logic                          align_in,
  input  logic [LANES-1:0]              valid_in,
  input  logic [LANES*IN_W-1:0]         data_in,
  output logic [$clog2(RATIO)-1:0]      phase_out,
  output logic [LANES-1:0]              valid_out,
  output logic [LANES*IN_W*RATIO-1:0]   data_out,
  output logic [LANES-1:0]              err_out
);

  localparam int PW = $clog2(RATIO);
  localparam int OW = IN_W * RATIO;
  localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] cur_p;
  logic [PW-1:0] slot;
  logic          frame_start;
  logic          frame_done;

  // align_in forces this edge to behave as phase 0; a frame is only
  // complete when the counter itself reached phase 0.
  always_comb begin
    cur_p       = align_in ? '0 : phase_q;
    frame_start = align_in | (phase_q == '0);
    frame_done  = (phase_q == '0);
    slot        = (MSB_FIRST != 0) ? (LAST - cur_p) : cur_p;
  end

  always_ff @(posedge clk_4f_c) begin
    if (!reset) begin
      phase_q <= '0;
    end else if (cur_p == LAST) begin
      phase_q <= '0;
    end else begin
      phase_q <= cur_p + PW'(1);
    end
  end

  assign phase_out = phase_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [OW-1:0]   acc_q;
    logic [OW-1:0]   acc_d;
    logic [OW-1:0]   word_q;
    logic [IN_W-1:0] smp;
    logic            smp_v;
    logic            all_q;
    logic            any_q;
    logic            vld_q;
    logic            err_q;
    logic            good;

    assign smp   = data_in[k*IN_W +: IN_W];
    assign smp_v = valid_in[k];
    assign good  = all_q & frame_done;

    always_comb begin
      acc_d = frame_start ? '0 : acc_q;
      if (smp_v) begin
        acc_d[slot*IN_W +: IN_W] = smp;
      end
    end

    always_ff @(posedge clk_4f_c) begin
      if (!reset) begin
        acc_q  <= '0;
        word_q <= '0;
        all_q  <= 1'b0;
        any_q  <= 1'b0;
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        acc_q <= acc_d;
        if (frame_start) begin
          all_q  <= smp_v;
          any_q  <= smp_v;
          vld_q  <= good;
          err_q  <= any_q & ~good;
          word_q <= good ? acc_q : '0;
        end else begin
          all_q <= all_q & smp_v;
          any_q <= any_q | smp_v;
        end
      end
    end

    assign valid_out[k]           = vld_q;
    assign err_out[k]             = err_q;
    assign data_out[k*OW +: OW]   = word_q;
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Scoreboard bench for byte_word_packer: MSB-first and LSB-first instances
// driven in parallel; expected frame results queued, monitor compares.
module tb_byte_word_packer;

  typedef struct packed {
    logic [1:0]  v;
    logic [1:0]  e;
    logic [63:0] dm;
    logic [63:0] dl;
  } exp_t;

  logic        clk_4f_c = 1'b0;
  logic        reset = 1'b0;
  logic        align_in = 1'b0;
  logic [1:0]  valid_in = '0;
  logic [15:0] data_in = '0;

  logic [1:0]  phase_m, phase_l;
  logic [1:0]  vo_m, vo_l, eo_m, eo_l;
  logic [63:0] do_m, do_l;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t hold = '0;
  logic rst_q = 1'b0;

  always #5 clk_4f_c = ~clk_4f_c;

  byte_word_packer #(.IN_W(8), .RATIO(4), .LANES(2), .MSB_FIRST(1)) dut_m (
    .clk_4f_c(clk_4f_c), .reset(reset), .align_in(align_in),
    .valid_in(valid_in), .data_in(data_in), .phase_out(phase_m),
    .valid_out(vo_m), .data_out(do_m), .err_out(eo_m));

  byte_word_packer #(.IN_W(8), .RATIO(4), .LANES(2), .MSB_FIRST(0)) dut_l (
    .clk_4f_c(clk_4f_c), .reset(reset), .align_in(align_in),
    .valid_in(valid_in), .data_in(data_in), .phase_out(phase_l),
    .valid_out(vo_l), .data_out(do_l), .err_out(eo_l));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [1:0] v, input logic [1:0] e,
                               input logic [63:0] dm, input logic [63:0] dl);
    exp_t x;
    x.v = v; x.e = e; x.dm = dm; x.dl = dl;
    sb.push_back(x);
  endfunction

  task automatic tick(input logic r, input logic al, input logic [1:0] v,
                      input logic [7:0] d0, input logic [7:0] d1);
    reset    = r;
    align_in = al;
    valid_in = v;
    data_in  = {d1, d0};
    @(posedge clk_4f_c);
    #1;
  endtask

  always @(posedge clk_4f_c) rst_q <= reset;

  // Outputs only change on frame-start edges, after which phase_out is 1.
  always @(negedge clk_4f_c) begin
    if (!rst_q) begin
      hold = '0;
    end else if (phase_m == 2'd1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=frame_edge expected=none t=%0t",
                 $time);
      end else begin
        hold = sb.pop_front();
      end
    end
    chk("valid_m", 64'(vo_m), 64'(hold.v));
    chk("err_m",   64'(eo_m), 64'(hold.e));
    chk("data_m",  do_m,      hold.dm);
    chk("valid_l", 64'(vo_l), 64'(hold.v));
    chk("err_l",   64'(eo_l), 64'(hold.e));
    chk("data_l",  do_l,      hold.dl);
  end

  initial begin
    tick(0, 0, 2'b00, 8'h00, 8'h00);
    tick(0, 0, 2'b00, 8'h00, 8'h00);
    chk("phase_rst", 64'(phase_m), 64'd0);

    // frame A: full on both lanes
    push(2'b00, 2'b00, 64'h0, 64'h0);
    tick(1, 0, 2'b11, 8'hAA, 8'h01);
    chk("phase_p1", 64'(phase_m), 64'd1);
    chk("phase_l1", 64'(phase_l), 64'd1);
    tick(1, 0, 2'b11, 8'hBB, 8'h02);
    chk("phase_p2", 64'(phase_m), 64'd2);
    tick(1, 0, 2'b11, 8'hCC, 8'h03);
    chk("phase_p3", 64'(phase_m), 64'd3);
    tick(1, 0, 2'b11, 8'hDD, 8'h04);
    chk("phase_wrap", 64'(phase_m), 64'd0);

    // frame B: lane1 drops at phase 2
    push(2'b11, 2'b00, 64'h01020304_AABBCCDD, 64'h04030201_DDCCBBAA);
    tick(1, 0, 2'b11, 8'h11, 8'h55);
    tick(1, 0, 2'b11, 8'h22, 8'h66);
    tick(1, 0, 2'b01, 8'h33, 8'h77);
    tick(1, 0, 2'b11, 8'h44, 8'h88);

    // frame C: full again on both lanes
    push(2'b01, 2'b10, 64'h00000000_11223344, 64'h00000000_44332211);
    tick(1, 0, 2'b11, 8'hA1, 8'hB1);
    tick(1, 0, 2'b11, 8'hA2, 8'hB2);
    tick(1, 0, 2'b11, 8'hA3, 8'hB3);
    tick(1, 0, 2'b11, 8'hA4, 8'hB4);

    // frame D: idle
    push(2'b11, 2'b00, 64'hB1B2B3B4_A1A2A3A4, 64'hB4B3B2B1_A4A3A2A1);
    repeat (4) tick(1, 0, 2'b00, 8'hFF, 8'hFF);

    // frame E: realign at phase 2
    push(2'b00, 2'b00, 64'h0, 64'h0);
    tick(1, 0, 2'b11, 8'hE0, 8'hF0);
    tick(1, 0, 2'b11, 8'hE1, 8'hF1);
    push(2'b00, 2'b11, 64'h0, 64'h0);
    tick(1, 1, 2'b11, 8'h11, 8'h99);
    chk("phase_align", 64'(phase_m), 64'd1);
    tick(1, 0, 2'b11, 8'h22, 8'h98);
    tick(1, 0, 2'b11, 8'h33, 8'h97);
    tick(1, 0, 2'b11, 8'h44, 8'h96);

    // frame F: align at phase 0 is a no-op, then reset at phase 2
    push(2'b11, 2'b00, 64'h99989796_11223344, 64'h96979899_44332211);
    tick(1, 1, 2'b11, 8'h5A, 8'h6A);
    chk("phase_align0", 64'(phase_m), 64'd1);
    tick(1, 0, 2'b11, 8'h5B, 8'h6B);
    tick(0, 1, 2'b11, 8'h5C, 8'h6C);
    chk("phase_midrst", 64'(phase_m), 64'd0);

    // frame G: lane0 only, first post-reset sample in slot 0
    push(2'b00, 2'b00, 64'h0, 64'h0);
    tick(1, 0, 2'b01, 8'h77, 8'h12);
    tick(1, 0, 2'b01, 8'h88, 8'h34);
    tick(1, 0, 2'b01, 8'h99, 8'h56);
    tick(1, 0, 2'b01, 8'hAA, 8'h78);

    push(2'b01, 2'b00, 64'h00000000_778899AA, 64'h00000000_AA998877);
    repeat (4) tick(1, 0, 2'b00, 8'h00, 8'h00);
    push(2'b00, 2'b00, 64'h0, 64'h0);
    tick(1, 0, 2'b00, 8'h00, 8'h00);
    repeat (3) @(negedge clk_4f_c);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
